// File: rtl/mul_div_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mul_div_unit_pkg
// Description : Shared MDU opcode encodings, latencies and result helper.
// Revision    : 1.0
// ============================================================================
package mul_div_unit_pkg;

    localparam logic [2:0] MDU_MULTU = 3'b000;
    localparam logic [2:0] MDU_MULT  = 3'b001;
    localparam logic [2:0] MDU_DIVU  = 3'b010;
    localparam logic [2:0] MDU_DIV   = 3'b011;

    localparam logic [3:0] MULT_CYC  = 4'd5;
    localparam logic [3:0] DIV_CYC   = 4'd10;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        keep;
    } mdu_result_t;

    function automatic logic op_is_valid(input logic [2:0] op);
        return (op[2] == 1'b0);
    endfunction

    function automatic logic [3:0] op_latency(input logic [2:0] op);
        return op[1] ? DIV_CYC : MULT_CYC;
    endfunction

    // Signed division runs on magnitudes so the 0x80000000 / -1 case needs no
    // special path; keep flags a divide-by-zero whose result must be dropped.
    function automatic mdu_result_t mdu_compute(input logic [2:0]  op,
                                                input logic [31:0] a,
                                                input logic [31:0] b);
        mdu_result_t res;
        logic [63:0] prod;
        logic [31:0] mag_a;
        logic [31:0] mag_b;
        logic [31:0] divisor;
        logic [31:0] quo;
        logic [31:0] rem;
        res     = '0;
        prod    = '0;
        mag_a   = (op[0] && a[31]) ? (32'd0 - a) : a;
        mag_b   = (op[0] && b[31]) ? (32'd0 - b) : b;
        divisor = (b == 32'd0) ? 32'd1 : mag_b;
        quo     = mag_a / divisor;
        rem     = mag_a % divisor;
        case (op)
            MDU_MULTU: begin
                prod   = {32'd0, a} * {32'd0, b};
                res.hi = prod[63:32];
                res.lo = prod[31:0];
            end
            MDU_MULT: begin
                prod   = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                res.hi = prod[63:32];
                res.lo = prod[31:0];
            end
            MDU_DIVU, MDU_DIV: begin
                if (op[0] && (a[31] ^ b[31])) begin
                    quo = 32'd0 - quo;
                end
                if (op[0] && a[31]) begin
                    rem = 32'd0 - rem;
                end
                res.lo   = quo;
                res.hi   = rem;
                res.keep = (b == 32'd0);
            end
            default: res = '0;
        endcase
        return res;
    endfunction

endpackage : mul_div_unit_pkg
`default_nettype wire

// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : mul_div_unit
// Description : Multi-cycle HI/LO multiply/divide unit with mthi/mtlo writes.
// Revision    : 1.0
// ============================================================================
module mul_div_unit
    import mul_div_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  MDUOp,
    input  logic        HIWrite,
    input  logic        LOWrite,
    input  logic        Req,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        Busy
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]  r_state;
    logic [0:0]  w_state_next;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_next;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_thi;
    logic [31:0] r_tlo;
    logic        r_keep;

    logic        w_issue_req;
    logic        w_done;
    logic        w_issue;
    logic        w_busy_q;
    logic        w_hi_we;
    logic        w_lo_we;
    mdu_result_t w_res;

    assign w_issue_req = start & ~Req & op_is_valid(MDUOp);
    assign w_done      = (r_state == ST_RUN) && (r_cnt == 4'd1);
    // A start on the completing edge is accepted: back-to-back issue.
    assign w_issue     = w_issue_req && ((r_state == ST_IDLE) || w_done);
    assign w_res       = mdu_compute(MDUOp, A, B);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_issue) begin
                    w_state_next = ST_RUN;
                    w_cnt_next   = op_latency(MDUOp);
                end
            end
            ST_RUN: begin
                w_cnt_next = r_cnt - 4'd1;
                if (w_done) begin
                    if (w_issue) begin
                        w_cnt_next = op_latency(MDUOp);
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_cnt_next   = 4'd0;
            end
        endcase
    end

    always_comb begin
        w_busy_q = (r_state == ST_RUN);
        Busy     = w_busy_q | w_issue_req;
        w_hi_we  = (r_state == ST_IDLE) & HIWrite & ~Req & ~w_issue_req;
        w_lo_we  = (r_state == ST_IDLE) & LOWrite & ~Req & ~w_issue_req;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hi   <= 32'd0;
            r_lo   <= 32'd0;
            r_thi  <= 32'd0;
            r_tlo  <= 32'd0;
            r_keep <= 1'b0;
        end else begin
            if (w_done && !r_keep) begin
                r_hi <= r_thi;
                r_lo <= r_tlo;
            end
            if (w_hi_we) begin
                r_hi <= A;
            end
            if (w_lo_we) begin
                r_lo <= A;
            end
            if (w_issue) begin
                r_thi  <= w_res.hi;
                r_tlo  <= w_res.lo;
                r_keep <= w_res.keep;
            end
        end
    end

    assign HI = r_hi;
    assign LO = r_lo;

endmodule : mul_div_unit
`default_nettype wire
